encoder_fixed_point_seq: RTL and testbench
==========================================

Name: encoder_fixed_point_seq

Overview:
Encoder half of the fixed-point autoencoder. It maps an N_input-wide feature vector to an M_output-wide latent vector: out_j = sum_i(x_i * w_ji) + b_j. It feeds the combinational decoder_fixed_point. To save area, it time-multiplexes one fixed_point_multiply and one fixed_point_add through a MAC state machine, with valid/ready handshakes on both sides.

Parameters:
N_input, 9, number of input features (>=1)
M_output, 2, number of latent outputs (>=1)
BITSIZE, 32, word width; team 32-bit fixed-point format

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  x valid
in_ready  output  1  block can accept x
x  input  N_input*BITSIZE  features; x_i = x[i*BITSIZE +: BITSIZE]
w  input  N_input*M_output*BITSIZE  weights; w_ji = w[(j*N_input+i)*BITSIZE +: BITSIZE] (same layout as decoder)
b  input  M_output*BITSIZE  bias; b_j = b[j*BITSIZE +: BITSIZE]
out_valid  output  1  out holds a finished result
out_ready  input  1  consumer accepts out
out  output  M_output*BITSIZE  latent vector; out_j = out[j*BITSIZE +: BITSIZE]

Behaviour:
- Reset (rst high at an edge): state IDLE, out=0, out_valid=0, acc=0, indices=0. in_ready=0 while rst is high.
- in_ready = (state==IDLE) && !rst. Combinational from state only, with no dependency on in_valid.
- FSM states: IDLE, MAC, BIAS, DONE.
- IDLE: on in_valid&&in_ready, register x into x_reg. Set i=0, j=0, acc=0. Go to MAC.
- MAC: one product per cycle. acc <= add(acc, mul(x_reg_i, w_ji)); i++. When i==N_input-1, go to BIAS.
- BIAS: out_j <= add(acc, b_j); acc<=0; i<=0. If j==M_output-1, go to DONE; otherwise j++ and go to MAC.
- DONE: out_valid=1. out is held stable until out_valid&&out_ready, then go to IDLE with out_valid=0.
- After the handshake, out keeps its last value while out_valid is low.
- Accumulation order is fixed: acc starts at 0, adds products for i=0..N_input-1 in order, then adds the bias. The golden model must use the same order, using fixed_point_multiply/fixed_point_add semantics (including their overflow behaviour).
- Latency: accept edge = cycle 0. MAC/BIAS occupy cycles 1..M_output*(N_input+1). out_valid rises at cycle M_output*(N_input+1)+1, which is cycle 21 with the defaults.
- Throughput: at best one vector every M_output*(N_input+1)+2 cycles. There is no input/output overlap.
- w and b are read live. They must stay stable from the accept edge until out_valid; the block does not check this.
- x is captured, so the producer may change it after the accept edge.
- in_valid outside IDLE is ignored. The producer must hold x/in_valid until in_ready.
- out_ready already high on entry to DONE: out_valid lasts exactly 1 cycle.
- N_input=1: one MAC cycle per output.
- Reset in any state aborts the computation. Partial results are discarded, and the next cycle shows IDLE and reset values.

Optional Feature:
Macro ENCODER_RELU_EN.
- Defined: in BIAS, if the sum's MSB (sign) is 1, store 0 into out_j; otherwise store the sum. Latency is unchanged.
- Undefined: store the raw sum. There is no extra logic.

Test Plan:
- Reset: hold rst 2 cycles, then release -> out=0 and out_valid=0 throughout; in_ready=0 during rst and 1 on the first cycle after.
- Zero input: x=all 0; b_0=0x00010000, b_1=0xFFFF0000; out_ready=1; accept at cycle 0 -> in_ready=0 cycles 1..21; out_valid=1 only at cycle 21 with out={0xFFFF0000,0x00010000}; in_ready=1 at cycle 22.
- Random: 200 random x/w/b vectors, random in_valid gaps -> every out is bit-exact against the golden model (sequential order, same multiply/add units); one result per accepted vector.
- Backpressure: out_ready low for 5 cycles after out_valid, with in_valid=1 and x changing -> out_valid and out stay stable, in_ready=0, nothing accepted; raise out_ready -> IDLE and the pending x is accepted next cycle.
- Reset mid-op: assert rst at cycle 7 after an accept -> next cycle out_valid=0, out=0, in_ready=1; a new vector then completes correctly at +21 cycles.
- ENCODER_RELU_EN: x=0, b_0=0xFFFF0000, b_1=0x00010000 -> with the macro, out_0=0 and out_1=0x00010000; without it, out_0=0xFFFF0000.

Source files
------------

// File: rtl/encoder_fixed_point_seq.sv
// Sequential fixed-point encoder: out_j = sum_i(x_i * w_ji) + b_j.
// Optional macro ENCODER_RELU_EN clamps negative sums to zero.
module encoder_fixed_point_seq #(
    parameter int N_input  = 9,
    parameter int M_output = 2,
    parameter int BITSIZE  = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [N_input*BITSIZE-1:0]             x,
    input  logic [N_input*M_output*BITSIZE-1:0]    w,
    input  logic [M_output*BITSIZE-1:0]            b,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [M_output*BITSIZE-1:0]            out
);

    localparam int IW   = (N_input > 1) ? $clog2(N_input) : 1;
    localparam int JW   = (M_output > 1) ? $clog2(M_output) : 1;
    localparam int FRAC = BITSIZE / 2;

    typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;

    state_t state, state_nxt;

    logic [N_input*BITSIZE-1:0]  x_reg;
    logic [M_output*BITSIZE-1:0] out_q;
    logic [BITSIZE-1:0]          acc;
    logic [BITSIZE-1:0]          x_sel, w_sel, b_sel;
    logic [BITSIZE-1:0]          mac_sum, bias_sum, res;
    logic [IW-1:0]               i;
    logic [JW-1:0]               j;
    logic                        last_i, last_j;

    // Signed fixed-point product, keeping the middle word (wraps on overflow).
    function automatic logic [BITSIZE-1:0] fx_mul(
        input logic [BITSIZE-1:0] a,
        input logic [BITSIZE-1:0] c
    );
        logic signed [2*BITSIZE-1:0] p;
        p = $signed({{BITSIZE{a[BITSIZE-1]}}, a})
          * $signed({{BITSIZE{c[BITSIZE-1]}}, c});
        return p[FRAC +: BITSIZE];
    endfunction

    // Two's-complement wrapping add.
    function automatic logic [BITSIZE-1:0] fx_add(
        input logic [BITSIZE-1:0] a,
        input logic [BITSIZE-1:0] c
    );
        return a + c;
    endfunction

    assign last_i = (i == IW'(N_input - 1));
    assign last_j = (j == JW'(M_output - 1));
    assign out    = out_q;

    // Operand selection for the shared multiplier and adder.
    always_comb begin
        x_sel = '0;
        w_sel = '0;
        b_sel = '0;
        for (int k = 0; k < N_input; k++)
            if (IW'(k) == i) x_sel = x_reg[k*BITSIZE +: BITSIZE];
        for (int k = 0; k < N_input*M_output; k++)
            if (k == int'(j)*N_input + int'(i)) w_sel = w[k*BITSIZE +: BITSIZE];
        for (int k = 0; k < M_output; k++)
            if (JW'(k) == j) b_sel = b[k*BITSIZE +: BITSIZE];
    end

    assign mac_sum  = fx_add(acc, fx_mul(x_sel, w_sel));
    assign bias_sum = fx_add(acc, b_sel);

`ifdef ENCODER_RELU_EN
    assign res = bias_sum[BITSIZE-1] ? '0 : bias_sum;
`else
    assign res = bias_sum;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_nxt = MAC;
            end
            MAC: begin
                if (last_i) state_nxt = BIAS;
            end
            BIAS: begin
                state_nxt = last_j ? DONE : MAC;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, accumulate, bias and store.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg <= '0;
            out_q <= '0;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg <= x;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                    end
                end
                MAC: begin
                    acc <= mac_sum;
                    i   <= i + 1'b1;
                end
                BIAS: begin
                    for (int k = 0; k < M_output; k++)
                        if (JW'(k) == j) out_q[k*BITSIZE +: BITSIZE] <= res;
                    acc <= '0;
                    i   <= '0;
                    if (!last_j) j <= j + 1'b1;
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_fixed_point_seq.sv
// Testbench for encoder_fixed_point_seq with a queue scoreboard.
// Expected results come from an independent 64-bit arithmetic model.
module tb_encoder_fixed_point_seq;

    localparam int N  = 9;
    localparam int M  = 2;
    localparam int B  = 32;
    localparam int OW = M*B;
    localparam int XW = N*B;
    localparam int WW = N*M*B;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] x;
    logic [WW-1:0] w;
    logic [OW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out;

    int checks  = 0;
    int errors  = 0;
    int pushed  = 0;
    int popped  = 0;
    int flushed = 0;

    logic [OW-1:0] sb_q[$];

    encoder_fixed_point_seq #(.N_input(N), .M_output(M), .BITSIZE(B)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .w(w), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] c);
        longint p;
        p = longint'(signed'(a)) * longint'(signed'(c));
        p = p >>> 16;
        return p[31:0];
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] c);
        return a + c;
    endfunction

    function automatic logic [OW-1:0] model(
        input logic [XW-1:0] xv,
        input logic [WW-1:0] wv,
        input logic [OW-1:0] bv
    );
        logic [OW-1:0] r;
        logic [31:0]   a, s;
        r = '0;
        for (int jj = 0; jj < M; jj++) begin
            a = 32'h0;
            for (int ii = 0; ii < N; ii++)
                a = m_add(a, m_mul(xv[ii*B +: B], wv[(jj*N+ii)*B +: B]));
            s = m_add(a, bv[jj*B +: B]);
`ifdef ENCODER_RELU_EN
            if (s[31]) s = 32'h0;
`endif
            r[jj*B +: B] = s;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(negedge clk) begin
        if (rst) begin
            flushed += sb_q.size();
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb_q.push_back(model(x, w, b));
                pushed++;
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", OW'(sb_q.size() > 0), OW'(1));
                if (sb_q.size() > 0) begin
                    chk("sb_out", out, sb_q.pop_front());
                    popped++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready(input bit rnd);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("in_ready_bound", OW'(in_ready), OW'(1));
    endtask

    task automatic send(
        input logic [XW-1:0] xv,
        input logic [WW-1:0] wv,
        input logic [OW-1:0] bv,
        input bit            rnd
    );
        wait_in_ready(rnd);
        x        = xv;
        w        = wv;
        b        = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic gen(output logic [XW-1:0] xv, output logic [WW-1:0] wv, output logic [OW-1:0] bv);
        for (int k = 0; k < N; k++) xv[k*B +: B] = $urandom;
        for (int k = 0; k < N*M; k++) wv[k*B +: B] = $urandom;
        for (int k = 0; k < M; k++) bv[k*B +: B] = $urandom;
    endtask

    initial begin
        logic [XW-1:0] xv;
        logic [WW-1:0] wv;
        logic [OW-1:0] bv;
        logic [OW-1:0] held;
        logic [OW-1:0] exp_v;
        int n;
        int p0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; w = '0; b = '0;

        // Reset held for two edges.
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_in_ready", OW'(in_ready), OW'(0));
            chk("rst_out_valid", OW'(out_valid), OW'(0));
            chk("rst_out", out, '0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", OW'(in_ready), OW'(1));
        chk("post_rst_out_valid", OW'(out_valid), OW'(0));

        // Zero input: output equals bias, exact cycle timing.
        gen(xv, wv, bv);
        out_ready = 1'b1;
        send('0, wv, 64'hFFFF0000_00010000, 1'b0);
        for (int k = 1; k <= 22; k++) begin
            chk($sformatf("zero_in_ready_c%0d", k), OW'(in_ready), OW'(k == 22));
            chk($sformatf("zero_out_valid_c%0d", k), OW'(out_valid), OW'(k == 21));
            if (k == 21) chk("zero_out", out, 64'hFFFF0000_00010000);
            step();
        end

        // Random vectors with gaps and random backpressure.
        for (int v = 0; v < 200; v++) begin
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
            gen(xv, wv, bv);
            send(xv, wv, bv, 1'b1);
        end
        out_ready = 1'b1;
        wait_in_ready(1'b0);

        // Backpressure: out held while consumer stalls.
        out_ready = 1'b0;
        gen(xv, wv, bv);
        send(xv, wv, bv, 1'b0);
        n = 0;
        while (!out_valid && n < 60) begin
            step();
            n++;
        end
        chk("bp_out_valid_seen", OW'(out_valid), OW'(1));
        held = out;
        p0 = pushed;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            x = {9{$urandom}};
            step();
            chk("bp_out_valid", OW'(out_valid), OW'(1));
            chk("bp_out_hold", out, held);
            chk("bp_in_ready", OW'(in_ready), OW'(0));
        end
        chk("bp_no_accept", OW'(pushed), OW'(p0));
        out_ready = 1'b1;
        step();
        chk("bp_idle_ready", OW'(in_ready), OW'(1));
        chk("bp_valid_low", OW'(out_valid), OW'(0));
        chk("bp_out_kept", out, held);
        step();
        in_valid = 1'b0;
        chk("bp_pending_accepted", OW'(pushed), OW'(p0 + 1));
        chk("bp_busy", OW'(in_ready), OW'(0));
        wait_in_ready(1'b0);

        // Reset in the middle of a computation.
        gen(xv, wv, bv);
        send(xv, wv, bv, 1'b0);
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", OW'(out_valid), OW'(0));
        chk("mid_rst_out", out, '0);
        chk("mid_rst_in_ready", OW'(in_ready), OW'(1));
        gen(xv, wv, bv);
        exp_v = model(xv, wv, bv);
        send(xv, wv, bv, 1'b0);
        n = 1;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk("mid_rst_latency", OW'(n), OW'(21));
        chk("mid_rst_result", out, exp_v);
        wait_in_ready(1'b0);

        // Negative sum: clamped with ReLU, raw otherwise.
        send('0, wv, 64'h00010000_FFFF0000, 1'b0);
        n = 1;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
`ifdef ENCODER_RELU_EN
        chk("relu_out", out, 64'h00010000_00000000);
`else
        chk("relu_out", out, 64'h00010000_FFFF0000);
`endif
        wait_in_ready(1'b0);
        step();

        chk("sb_drained", OW'(sb_q.size()), OW'(0));
        chk("result_count", OW'(popped), OW'(pushed - flushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
